fb_port_arbiter: RTL and testbench

Arbitrates a single-port 320×240×16-bit frame-buffer RAM between the camera capture writer and one pixel reader (display/processing). Capture writes cannot be back-pressured, so they are absorbed by a small write FIFO and drained with watermark-based priority. The reader uses a req/gnt handshake and gets a fixed-latency `rd_valid` response. The block sits between the capture module (`addr`/`dout`/`we`) and the frame-buffer BRAM.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/fb_port_arbiter_if.sv | 52 +++++
 rtl/fb_wr_fifo.sv | 81 ++++++++
 rtl/fb_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fb_pkg
// Purpose  : Shared types and constants for the frame-buffer port arbiter.
//            Pixel address/data widths, frame size, the write-FIFO entry
//            type and the arbitration selection encoding.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
package fb_pkg;

   localparam int FB_ADDR_W = 17;
   localparam int FB_DATA_W = 16;
   localparam int FB_NPIX   = 76800;   // 320 x 240

   // One pending capture write
   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } fb_wr_t;

   // Per-cycle arbitration outcome
   typedef enum logic [1:0] {
      SEL_IDLE = 2'd0,
      SEL_WR   = 2'd1,
      SEL_RD   = 2'd2
   } arb_sel_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_port_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fb_port_arbiter_if
// Purpose  : Bundles the capture, reader and RAM-side signals of the
//            frame-buffer port arbiter.
//            master : client/environment view (capture, reader, RAM model)
//            slave  : arbiter view
// Signals  : cap_we/cap_addr/cap_din  capture write strobe, address, pixel
//            hold                     suspend new RAM accesses
//            rd_req/rd_addr           reader request and address
//            rd_gnt/rd_valid/rd_data  grant pulse, response pulse, pixel
//            ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM port
//            ovf/range_err            sticky error flags
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface fb_port_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_W = FB_ADDR_W,
   parameter int DATA_W = FB_DATA_W
);
   logic              cap_we;
   logic [ADDR_W-1:0] cap_addr;
   logic [DATA_W-1:0] cap_din;
   logic              hold;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ovf;
   logic              range_err;

   modport master (
      output cap_we, cap_addr, cap_din, hold, rd_req, rd_addr, ram_rdata,
      input  rd_gnt, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata,
             ovf, range_err
   );

   modport slave (
      input  cap_we, cap_addr, cap_din, hold, rd_req, rd_addr, ram_rdata,
      output rd_gnt, rd_valid, rd_data, ram_en, ram_we, ram_addr, ram_wdata,
             ovf, range_err
   );

endinterface : fb_port_arbiter_if
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fb_wr_fifo
// Purpose  : Synchronous FIFO of capture writes. A push into a full FIFO is
//            accepted only when a pop happens in the same cycle; otherwise
//            it is dropped and o_drop pulses.
// Ports    : clk, rst           clock, async active-high reset
//            i_push, i_din      push request and entry
//            i_pop              pop head (ignored when empty)
//            o_head             current head entry
//            o_count            occupancy
//            o_full, o_empty    status
//            o_drop             push discarded this cycle
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  fb_wr_t                       i_din,
   input  logic                         i_pop,
   output fb_wr_t                       o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_drop
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   fb_wr_t               r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic                 w_wr_en;
   logic                 w_rd_en;

   assign o_full  = (r_count == c_CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // When full, the slot being written is the one being popped this cycle
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);
   assign o_drop  = i_push && !w_wr_en;

   // Storage carries no reset; only pointers and count define validity
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : fb_wr_fifo
`default_nettype wire

// File: rtl/fb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fb_port_arbiter
// Purpose  : Shares one single-port frame-buffer RAM between the capture
//            writer (buffered through fb_wr_fifo, never back-pressured) and a
//            req/gnt pixel reader with fixed-latency rd_valid responses.
//            Writes win once the FIFO reaches HI_WM; otherwise a pending read
//            wins unless it was granted in the previous cycle.
// Ports    : clk, rst    clock, async active-high reset
//            bus (slave) capture, reader, RAM and flag signals
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int NPIX       = FB_NPIX,
   parameter int FIFO_DEPTH = 4,
   parameter int HI_WM      = 2,
   parameter int RD_LAT     = 1
)(
   input  logic               clk,
   input  logic               rst,
   fb_port_arbiter_if.slave   bus
);

   localparam int                 c_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W-1:0]  c_NPIX  = ADDR_W'(NPIX);
   localparam logic [c_CNT_W-1:0] c_HI_WM = c_CNT_W'(HI_WM);

   arb_sel_t              r_sel;
   arb_sel_t              w_sel;
   fb_wr_t                w_cap_entry;
   fb_wr_t                w_head;
   logic [c_CNT_W-1:0]    w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_drop;
   logic                  w_cap_inr;
   logic                  w_rd_inr;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_rd_sel;

   logic                  r_rd_gnt;
   logic                  r_rd_valid;
   logic [DATA_W-1:0]     r_rd_data;
   logic                  r_ram_en;
   logic                  r_ram_we;
   logic [ADDR_W-1:0]     r_ram_addr;
   logic [DATA_W-1:0]     r_ram_wdata;
   logic                  r_ovf;
   logic                  r_range_err;
   // Bit k set: a read granted k cycles ago is in flight
   logic [RD_LAT:0]       r_vpipe;
   // Matching bit set: that read was out of range and must return zero
   logic [RD_LAT:0]       r_zpipe;

   assign w_cap_inr        = (bus.cap_addr < c_NPIX);
   assign w_rd_inr         = (bus.rd_addr  < c_NPIX);
   assign w_push           = bus.cap_we && w_cap_inr;
   assign w_cap_entry.addr = bus.cap_addr;
   assign w_cap_entry.data = bus.cap_din;

   fb_wr_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_cap_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_drop  (w_drop)
   );

   // Arbitration state: last cycle's decision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel <= SEL_IDLE;
      end else begin
         r_sel <= w_sel;
      end
   end

   // Next decision. Full is included so a watermark above the FIFO depth
   // still lets writes win before capture data is lost.
   always_comb begin
      w_sel = SEL_IDLE;
      if (!bus.hold) begin
         if ((w_count >= c_HI_WM) || w_full) begin
            w_sel = SEL_WR;
         end else if (bus.rd_req && (r_sel != SEL_RD)) begin
            w_sel = SEL_RD;
         end else if (!w_empty) begin
            w_sel = SEL_WR;
         end
      end
   end

   assign w_pop    = (w_sel == SEL_WR);
   assign w_rd_sel = (w_sel == SEL_RD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_gnt    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_data   <= '0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ovf       <= 1'b0;
         r_range_err <= 1'b0;
         r_vpipe     <= '0;
         r_zpipe     <= '0;
      end else begin
         r_rd_gnt <= w_rd_sel;
         // Out-of-range reads are granted but never touch the RAM
         r_ram_en <= w_pop || (w_rd_sel && w_rd_inr);
         r_ram_we <= w_pop;
         if (w_pop) begin
            r_ram_addr  <= w_head.addr;
            r_ram_wdata <= w_head.data;
         end else if (w_rd_sel && w_rd_inr) begin
            r_ram_addr  <= bus.rd_addr;
         end

         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if ((bus.cap_we && !w_cap_inr) || (w_rd_sel && !w_rd_inr)) begin
            r_range_err <= 1'b1;
         end

         // Stage 0 lines up with rd_gnt; stage RD_LAT with valid ram_rdata
         r_vpipe    <= {r_vpipe[RD_LAT-1:0], w_rd_sel};
         r_zpipe    <= {r_zpipe[RD_LAT-1:0], w_rd_sel && !w_rd_inr};
         r_rd_valid <= r_vpipe[RD_LAT];
         if (r_vpipe[RD_LAT]) begin
            r_rd_data <= r_zpipe[RD_LAT] ? '0 : bus.ram_rdata;
         end
      end
   end

   assign bus.rd_gnt    = r_rd_gnt;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_data;
   assign bus.ram_en    = r_ram_en;
   assign bus.ram_we    = r_ram_we;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.ovf       = r_ovf;
   assign bus.range_err = r_range_err;

endmodule : fb_port_arbiter
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fb_port_arbiter
// Purpose  : Self-checking bench for fb_port_arbiter. Directed cases for the
//            basic write/read timing, overflow, range and reset, plus a
//            randomized phase. The expected RAM write stream, read responses
//            and their timing come from a transaction-level model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_fb_port_arbiter;
   import fb_pkg::*;

   localparam int NPIX   = FB_NPIX;
   localparam int DEPTH  = 4;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } rd_exp_t;

   logic clk;
   logic rst;

   fb_port_arbiter_if #(.ADDR_W(FB_ADDR_W), .DATA_W(FB_DATA_W)) ifc ();

   fb_port_arbiter #(
      .ADDR_W     (FB_ADDR_W),
      .DATA_W     (FB_DATA_W),
      .NPIX       (NPIX),
      .FIFO_DEPTH (DEPTH),
      .HI_WM      (2),
      .RD_LAT     (1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int      cyc = 0;
   int      n_vec = 0;
   int      n_err = 0;
   int      n_wr = 0;
   int      n_gnt = 0;
   int      n_val = 0;
   int      last_wr_cyc = -1;
   fb_wr_t  exp_wr[$];
   rd_exp_t exp_rd[$];

   // stimulus modes
   int      wr_mode = 0;       // 0 off, 1 random, 2 every 2nd cycle
   int      wr_left = 0;
   int      wr_idx = 0;
   bit      last_we = 1'b0;
   bit      rd_mode = 1'b0;
   int      rd_pct = 0;
   bit      rd_oob = 1'b0;
   bit      gnt_prev = 1'b0;
   bit      hold_mode = 1'b0;
   int      hold_left = 0;
   int      hold_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Content the RAM model returns for an address
   function automatic logic [15:0] ram_fn(input logic [16:0] a);
      if (a == 17'd100) return 16'h1234;
      return (a[15:0] * 16'h9E37) ^ {15'h2D2D, a[16]};
   endfunction

   // RAM model with one cycle of read latency; garbage when not reading
   always @(posedge clk) begin
      if (ifc.ram_en && !ifc.ram_we) ifc.ram_rdata <= ram_fn(ifc.ram_addr);
      else                           ifc.ram_rdata <= 16'hDEAD;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Transaction monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         exp_wr.delete();
         exp_rd.delete();
      end else begin
         if (ifc.ram_en && ifc.ram_we) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
               chk("wr_unexpected", 32'(ifc.ram_addr), 32'hFFFF_FFFF);
            end else begin
               fb_wr_t e;
               e = exp_wr.pop_front();
               chk("wr_addr", 32'(ifc.ram_addr),  32'(e.addr));
               chk("wr_data", 32'(ifc.ram_wdata), 32'(e.data));
            end
         end
         if (ifc.rd_gnt) begin
            rd_exp_t r;
            n_gnt++;
            r.cyc = cyc + 2;
            if (ifc.rd_addr < 17'(NPIX)) begin
               chk("rd_ram_cmd",  32'({ifc.ram_en, ifc.ram_we}), 32'd2);
               chk("rd_ram_addr", 32'(ifc.ram_addr), 32'(ifc.rd_addr));
               r.data = ram_fn(ifc.rd_addr);
            end else begin
               chk("oob_no_ram", 32'(ifc.ram_en), 32'd0);
               r.data = 16'h0000;
            end
            exp_rd.push_back(r);
         end else if (ifc.ram_en && !ifc.ram_we) begin
            chk("rd_without_gnt", 32'(ifc.ram_en), 32'd0);
         end
         if (ifc.rd_valid) begin
            n_val++;
            if (exp_rd.size() == 0) begin
               chk("val_unexpected", 32'(ifc.rd_valid), 32'd0);
            end else begin
               rd_exp_t r;
               r = exp_rd.pop_front();
               chk("val_cycle", 32'(cyc), 32'(r.cyc));
               chk("val_data",  32'(ifc.rd_data), 32'(r.data));
            end
         end
      end
   end

   task automatic drive_cap(input logic [16:0] a, input logic [15:0] d, input bit expect_it);
      fb_wr_t e;
      ifc.cap_we   = 1'b1;
      ifc.cap_addr = a;
      ifc.cap_din  = d;
      if (expect_it && (a < 17'(NPIX))) begin
         e.addr = a;
         e.data = d;
         exp_wr.push_back(e);
      end
   endtask

   task automatic new_req();
      ifc.rd_req = 1'b1;
      if (rd_oob && ($urandom_range(0, 9) == 0))
         ifc.rd_addr = 17'(NPIX + $urandom_range(0, 200));
      else
         ifc.rd_addr = 17'($urandom_range(0, NPIX - 1));
   endtask

   // Advance one cycle and set default inputs for the new cycle
   task automatic step();
      @(posedge clk);
      #1;
      // reader: keep request until granted, may change only the cycle after
      if (ifc.rd_req && gnt_prev) begin
         if (rd_mode && ($urandom_range(0, 99) < rd_pct)) new_req();
         else ifc.rd_req = 1'b0;
      end else if (!ifc.rd_req && rd_mode && ($urandom_range(0, 99) < rd_pct)) begin
         new_req();
      end
      gnt_prev = ifc.rd_gnt;
      // capture writer
      ifc.cap_we = 1'b0;
      if (wr_mode == 1) begin
         if (!last_we && ($urandom_range(0, 1) == 1)) begin
            if ($urandom_range(0, 15) == 0)
               drive_cap(17'(NPIX + $urandom_range(0, 100)), 16'($urandom), 1'b1);
            else
               drive_cap(17'($urandom_range(0, NPIX - 1)), 16'($urandom), 1'b1);
         end
      end else if (wr_mode == 2) begin
         if (!last_we && (wr_left > 0)) begin
            drive_cap(17'(wr_idx), 16'($urandom), 1'b1);
            wr_idx++;
            wr_left--;
         end
      end
      last_we = ifc.cap_we;
      // short random hold bursts
      ifc.hold = 1'b0;
      if (hold_left > 0) begin
         ifc.hold = 1'b1;
         hold_left--;
         if (hold_left == 0) hold_gap = 10;
      end else if (hold_gap > 0) begin
         hold_gap--;
      end else if (hold_mode && ($urandom_range(0, 9) == 0)) begin
         hold_left = $urandom_range(1, 2);
      end
   endtask

   task automatic drain();
      int k;
      wr_mode   = 0;
      rd_mode   = 1'b0;
      hold_mode = 1'b0;
      k = 0;
      while ((k < 300) && ((exp_wr.size() != 0) || (exp_rd.size() != 0) ||
             ifc.rd_req || (hold_left != 0))) begin
         step();
         k++;
      end
      step();
      step();
      chk("drain_wr_left", 32'(exp_wr.size()), 32'd0);
      chk("drain_rd_left", 32'(exp_rd.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      int w0;
      int g0;
      int v0;

      rst           = 1'b1;
      ifc.cap_we    = 1'b0;
      ifc.cap_addr  = '0;
      ifc.cap_din   = '0;
      ifc.hold      = 1'b0;
      ifc.rd_req    = 1'b0;
      ifc.rd_addr   = '0;
      ifc.ram_rdata = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", 32'({ifc.rd_gnt, ifc.rd_valid, ifc.ram_en, ifc.ram_we,
                              ifc.ovf, ifc.range_err}), 32'd0);
      chk("reset_data", 32'({ifc.rd_data, ifc.ram_wdata}), 32'd0);
      chk("reset_addr", 32'(ifc.ram_addr), 32'd0);
      rst = 1'b0;
      step();
      step();

      // single write, reader idle
      step();
      drive_cap(17'd5, 16'hABCD, 1'b1);
      c0 = cyc;
      w0 = n_wr;
      step();
      chk("wr1_not_early", 32'(ifc.ram_en), 32'd0);
      step();
      chk("wr1_cmd",   32'({ifc.ram_en, ifc.ram_we}), 32'd3);
      chk("wr1_addr",  32'(ifc.ram_addr), 32'd5);
      chk("wr1_wdata", 32'(ifc.ram_wdata), 32'hABCD);
      step();
      chk("wr1_once", 32'(ifc.ram_en), 32'd0);
      step();
      chk("wr1_count", 32'(n_wr - w0), 32'd1);
      chk("wr1_cycle", 32'(last_wr_cyc - c0), 32'd2);

      // single read
      step();
      ifc.rd_req  = 1'b1;
      ifc.rd_addr = 17'd100;
      step();
      chk("rd1_gnt",  32'({ifc.rd_gnt, ifc.ram_en, ifc.ram_we}), 32'd6);
      chk("rd1_addr", 32'(ifc.ram_addr), 32'd100);
      step();
      chk("rd1_gnt_pulse", 32'({ifc.rd_gnt, ifc.rd_valid}), 32'd0);
      step();
      chk("rd1_valid", 32'(ifc.rd_valid), 32'd1);
      chk("rd1_data",  32'(ifc.rd_data), 32'h1234);
      step();
      chk("rd1_valid_pulse", 32'(ifc.rd_valid), 32'd0);

      // contention: 320 writes every 2nd cycle, continuous reader
      drain();
      w0 = n_wr; g0 = n_gnt; v0 = n_val;
      wr_idx  = 0;
      wr_left = 320;
      wr_mode = 2;
      rd_mode = 1'b1;
      rd_pct  = 100;
      while (wr_left > 0) step();
      drain();
      chk("cont_ovf",     32'(ifc.ovf), 32'd0);
      chk("cont_writes",  32'(n_wr - w0), 32'd320);
      chk("cont_rd_pair", 32'(n_val - v0), 32'(n_gnt - g0));
      chk("cont_rd_some", 32'((n_gnt - g0) > 50), 32'd1);

      // range errors
      chk("range_clear", 32'(ifc.range_err), 32'd0);
      w0 = n_wr;
      step();
      drive_cap(17'd76800, 16'h5555, 1'b1);
      step();
      step();
      step();
      chk("range_cap_flag",  32'(ifc.range_err), 32'd1);
      chk("range_cap_no_wr", 32'(n_wr - w0), 32'd0);
      step();
      ifc.rd_req  = 1'b1;
      ifc.rd_addr = 17'd76801;
      step();
      chk("range_rd_gnt", 32'({ifc.rd_gnt, ifc.ram_en}), 32'd2);
      step();
      step();
      chk("range_rd_valid", 32'(ifc.rd_valid), 32'd1);
      chk("range_rd_zero",  32'(ifc.rd_data), 32'd0);

      // randomized traffic with short hold bursts
      drain();
      w0 = n_wr; g0 = n_gnt; v0 = n_val;
      wr_mode   = 1;
      rd_mode   = 1'b1;
      rd_pct    = 40;
      rd_oob    = 1'b1;
      hold_mode = 1'b1;
      repeat (2000) step();
      drain();
      chk("rand_ovf",     32'(ifc.ovf), 32'd0);
      chk("rand_rd_pair", 32'(n_val - v0), 32'(n_gnt - g0));
      chk("rand_wr_some", 32'((n_wr - w0) > 200), 32'd1);

      // overflow while held: only the first DEPTH samples survive
      w0 = n_wr;
      for (int i = 0; i < 5; i++) begin
         step();
         ifc.hold = 1'b1;
         drive_cap(17'(i), 16'(16'hC000 + i), (i < DEPTH));
      end
      step();
      ifc.hold = 1'b1;
      chk("ovf_set",      32'(ifc.ovf), 32'd1);
      chk("ovf_held",     32'(n_wr - w0), 32'd0);
      drain();
      chk("ovf_writes",   32'(n_wr - w0), 32'(DEPTH));
      chk("ovf_sticky",   32'(ifc.ovf), 32'd1);

      // reset one cycle after a grant
      step();
      ifc.rd_req  = 1'b1;
      ifc.rd_addr = 17'd200;
      step();
      chk("rstmid_gnt", 32'(ifc.rd_gnt), 32'd1);
      step();
      v0 = n_val;
      rst = 1'b1;
      #1;
      chk("rstmid_flags", 32'({ifc.rd_gnt, ifc.rd_valid, ifc.ram_en, ifc.ram_we,
                               ifc.ovf, ifc.range_err}), 32'd0);
      chk("rstmid_addr",  32'(ifc.ram_addr), 32'd0);
      chk("rstmid_data",  32'({ifc.rd_data, ifc.ram_wdata}), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) step();
      chk("rstmid_no_valid", 32'(n_val - v0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fb_port_arbiter
`default_nettype wire
